bf_program_loader: RTL and testbench

Encoder front end for the brainfuck core. Accepts an ASCII source stream one byte at a time, drops non-command characters and encodes the eight command characters into the 3-bit command code that bf_command_runner executes. It writes each code to command memory at consecutive addresses from 0, checks bracket balance on the fly, and reports the program length or an error code. It sits between the host/UART byte source and the command memory written ahead of a run.

---
 rtl/bf_pkg.sv | 37 +++
 rtl/bf_program_loader_if.sv | 30 +++
 rtl/bf_char_encoder.sv | 28 ++
 rtl/bf_program_loader.sv | 138 +++++++++++++
 tb/tb_bf_program_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core: command codes, source characters,
// loader states and loader error codes.
package bf_pkg;

    typedef enum logic [2:0] {
        CMD_INC        = 3'b000,
        CMD_DEC        = 3'b001,
        CMD_LOOP_OPEN  = 3'b010,
        CMD_LOOP_CLOSE = 3'b011,
        CMD_PTR_INC    = 3'b100,
        CMD_PTR_DEC    = 3'b101,
        CMD_OUT        = 3'b110,
        CMD_IN         = 3'b111
    } bf_cmd_e;

    localparam logic [7:0] ASCII_PLUS    = 8'h2B;
    localparam logic [7:0] ASCII_MINUS   = 8'h2D;
    localparam logic [7:0] ASCII_LBRACK  = 8'h5B;
    localparam logic [7:0] ASCII_RBRACK  = 8'h5D;
    localparam logic [7:0] ASCII_GREATER = 8'h3E;
    localparam logic [7:0] ASCII_LESS    = 8'h3C;
    localparam logic [7:0] ASCII_PERIOD  = 8'h2E;
    localparam logic [7:0] ASCII_COMMA   = 8'h2C;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE,
        LD_ERROR
    } loader_state_e;

    localparam logic [1:0] ERR_NONE            = 2'b00;
    localparam logic [1:0] ERR_UNMATCHED_CLOSE = 2'b01;
    localparam logic [1:0] ERR_UNCLOSED_OPEN   = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW        = 2'b11;

endpackage

// File: rtl/bf_program_loader_if.sv
// Byte-stream, command-memory write and status signals of the program loader.
// The loader is the slave; the host / byte source side is the master.
interface bf_program_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  start_trigger;
    logic                  char_valid;
    logic [7:0]            char_data;
    logic                  char_ready;
    logic                  end_trigger;
    logic                  mem_write_trigger;
    logic [ADDR_WIDTH-1:0] mem_addr;
    bf_pkg::bf_cmd_e       mem_command;
    logic [ADDR_WIDTH-1:0] program_length;
    logic                  done;
    logic                  error;
    logic [1:0]            error_code;

    modport master (
        output start_trigger, char_valid, char_data, end_trigger,
        input  char_ready, mem_write_trigger, mem_addr, mem_command,
        input  program_length, done, error, error_code
    );

    modport slave (
        input  start_trigger, char_valid, char_data, end_trigger,
        output char_ready, mem_write_trigger, mem_addr, mem_command,
        output program_length, done, error, error_code
    );
endinterface

// File: rtl/bf_char_encoder.sv
// Combinational ASCII -> command encoder; any byte that is not one of the
// eight command characters reports o_is_command = 0.
module bf_char_encoder
    import bf_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_is_command,
    output bf_cmd_e    o_code
);

    always_comb begin
        // NOTE: defaults first so every path drives both outputs and no latch is inferred.
        o_is_command = 1'b1;
        o_code       = CMD_INC;
        case (i_char)
            ASCII_PLUS:    o_code = CMD_INC;
            ASCII_MINUS:   o_code = CMD_DEC;
            ASCII_LBRACK:  o_code = CMD_LOOP_OPEN;
            ASCII_RBRACK:  o_code = CMD_LOOP_CLOSE;
            ASCII_GREATER: o_code = CMD_PTR_INC;
            ASCII_LESS:    o_code = CMD_PTR_DEC;
            ASCII_PERIOD:  o_code = CMD_OUT;
            ASCII_COMMA:   o_code = CMD_IN;
            default:       o_is_command = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_program_loader.sv
// Loads a brainfuck source byte stream into command memory, checking bracket
// balance and capacity on the fly and reporting length or an error code.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int PROGRAM_SIZE = 65536,
    parameter int MAX_DEPTH    = 255,
    parameter int DEPTH_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          reset_trigger,
    bf_program_loader_if.slave bus
);

    // One extra bit so a completely full memory (PROGRAM_SIZE == 2**ADDR_WIDTH)
    // is distinguishable from an empty one.
    localparam int                     COUNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT  = COUNT_WIDTH'(PROGRAM_SIZE);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_LIMIT = DEPTH_WIDTH'(MAX_DEPTH);

    loader_state_e          r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    bf_cmd_e                r_command;
    logic                   r_done;
    logic                   r_error;
    logic [1:0]             r_error_code;

    logic                   w_is_command;
    bf_cmd_e                w_code;
    logic                   w_accept;
    logic                   w_do_write;
    logic                   w_byte_error;
    logic [1:0]             w_byte_error_code;
    logic [DEPTH_WIDTH-1:0] w_next_depth;

    bf_char_encoder u_encoder (
        .i_char       (bus.char_data),
        .o_is_command (w_is_command),
        .o_code       (w_code)
    );

    assign w_accept = (r_state == LD_LOAD) && bus.char_valid;

    // Classify the accepted byte; capacity is checked before brackets, and an
    // offending byte never reaches memory.
    always_comb begin
        w_do_write        = 1'b0;
        w_byte_error      = 1'b0;
        w_byte_error_code = ERR_NONE;
        w_next_depth      = r_depth;
        if (w_accept && w_is_command) begin
            if (r_count == FULL_COUNT) begin
                w_byte_error      = 1'b1;
                w_byte_error_code = ERR_OVERFLOW;
            end else if (w_code == CMD_LOOP_OPEN && r_depth == DEPTH_LIMIT) begin
                w_byte_error      = 1'b1;
                w_byte_error_code = ERR_OVERFLOW;
            end else if (w_code == CMD_LOOP_CLOSE && r_depth == '0) begin
                w_byte_error      = 1'b1;
                w_byte_error_code = ERR_UNMATCHED_CLOSE;
            end else begin
                w_do_write = 1'b1;
                if (w_code == CMD_LOOP_OPEN) begin
                    w_next_depth = r_depth + DEPTH_WIDTH'(1);
                end else if (w_code == CMD_LOOP_CLOSE) begin
                    w_next_depth = r_depth - DEPTH_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here sees the pre-edge values.
        if (reset_trigger) begin
            r_state      <= LD_IDLE;
            r_count      <= '0;
            r_depth      <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_command    <= CMD_INC;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= ERR_NONE;
        end else begin
            r_write <= 1'b0;
            if (bus.start_trigger) begin
                r_state      <= LD_LOAD;
                r_count      <= '0;
                r_depth      <= '0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
                r_error_code <= ERR_NONE;
            end else begin
                case (r_state)
                    LD_LOAD: begin
                        if (w_do_write) begin
                            r_write   <= 1'b1;
                            r_addr    <= r_count[ADDR_WIDTH-1:0];
                            r_command <= w_code;
                            r_count   <= r_count + COUNT_WIDTH'(1);
                            r_depth   <= w_next_depth;
                        end
                        // The byte is processed before a coincident end marker.
                        if (w_byte_error) begin
                            r_state      <= LD_ERROR;
                            r_error      <= 1'b1;
                            r_error_code <= w_byte_error_code;
                        end else if (bus.end_trigger) begin
                            if (w_next_depth == '0) begin
                                r_state <= LD_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= LD_ERROR;
                                r_error      <= 1'b1;
                                r_error_code <= ERR_UNCLOSED_OPEN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.char_ready        = (r_state == LD_LOAD);
    assign bus.mem_write_trigger = r_write;
    assign bus.mem_addr          = r_addr;
    assign bus.mem_command       = r_command;
    assign bus.program_length    = r_count[ADDR_WIDTH-1:0];
    assign bus.done              = r_done;
    assign bus.error             = r_error;
    assign bus.error_code        = r_error_code;

endmodule

// File: tb/tb_bf_program_loader.sv
// Drives a full-size loader and a small one (MAX_DEPTH=2, PROGRAM_SIZE=4) with
// identical byte streams and compares both against a behavioural model.
module tb_bf_program_loader;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_DONE = 2;
    localparam int S_ERR  = 3;

    logic clk = 1'b0;
    logic reset_trigger = 1'b1;
    always #5 clk = ~clk;

    bf_program_loader_if #(.ADDR_WIDTH(16)) bus_a ();
    bf_program_loader_if #(.ADDR_WIDTH(16)) bus_b ();

    bf_program_loader #(
        .ADDR_WIDTH(16), .PROGRAM_SIZE(65536), .MAX_DEPTH(255), .DEPTH_WIDTH(8)
    ) u_dut_main (
        .clk(clk), .reset_trigger(reset_trigger), .bus(bus_a)
    );

    bf_program_loader #(
        .ADDR_WIDTH(16), .PROGRAM_SIZE(4), .MAX_DEPTH(2), .DEPTH_WIDTH(8)
    ) u_dut_small (
        .clk(clk), .reset_trigger(reset_trigger), .bus(bus_b)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model, one slot per DUT.
    string cmd_chars = "+-[]><.,";
    int psize [2] = '{65536, 4};
    int maxd  [2] = '{255, 2};
    int m_state [2];
    int m_count [2];
    int m_depth [2];
    int m_done  [2];
    int m_err   [2];
    int m_code  [2];
    int m_write [2];
    int m_addr  [2];
    int m_cmd   [2];

    // Observed memory traffic.
    logic [2:0] dmem [2][16];
    int wcount  [2];
    int last_addr [2];
    bit wrote_addr4 [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (cmd_chars[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input int k, input logic rst, input logic st,
                                       input logic v, input logic [7:0] d, input logic e);
        int c;
        int bad;
        m_write[k] = 0;
        if (rst) begin
            m_state[k] = S_IDLE; m_count[k] = 0; m_depth[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_code[k] = 0; m_addr[k] = 0; m_cmd[k] = 0;
            return;
        end
        if (st) begin
            m_state[k] = S_LOAD; m_count[k] = 0; m_depth[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_code[k] = 0;
            return;
        end
        if (m_state[k] != S_LOAD) return;
        bad = 0;
        c = v ? enc(d) : -1;
        if (c >= 0) begin
            if (m_count[k] == psize[k]) bad = 3;
            else if (c == 2 && m_depth[k] == maxd[k]) bad = 3;
            else if (c == 3 && m_depth[k] == 0) bad = 1;
            else begin
                m_write[k] = 1;
                m_addr[k] = m_count[k];
                m_cmd[k] = c;
                m_count[k]++;
                if (c == 2) m_depth[k]++;
                if (c == 3) m_depth[k]--;
            end
        end
        if (bad != 0) begin
            m_state[k] = S_ERR; m_err[k] = 1; m_code[k] = bad;
        end else if (e) begin
            if (m_depth[k] == 0) begin
                m_state[k] = S_DONE; m_done[k] = 1;
            end else begin
                m_state[k] = S_ERR; m_err[k] = 1; m_code[k] = 2;
            end
        end
    endfunction

    task automatic cmp_one(input int k, input logic rdy, input logic wr, input logic [15:0] addr,
                           input logic [2:0] cmd, input logic [15:0] len, input logic dn,
                           input logic er, input logic [1:0] ec);
        check($sformatf("u%0d char_ready", k), rdy, (m_state[k] == S_LOAD));
        check($sformatf("u%0d mem_write_trigger", k), wr, m_write[k]);
        if (m_write[k] != 0 || m_state[k] == S_IDLE) begin
            check($sformatf("u%0d mem_addr", k), addr, m_addr[k]);
            check($sformatf("u%0d mem_command", k), cmd, m_cmd[k]);
        end
        check($sformatf("u%0d program_length", k), len, m_count[k] & 32'hFFFF);
        check($sformatf("u%0d done", k), dn, m_done[k]);
        check($sformatf("u%0d error", k), er, m_err[k]);
        check($sformatf("u%0d error_code", k), ec, m_code[k]);
    endtask

    // Capture writes and compare both DUTs against the model on every cycle.
    always @(negedge clk) begin
        if (bus_a.mem_write_trigger) begin
            if (bus_a.mem_addr < 16) dmem[0][bus_a.mem_addr[3:0]] = bus_a.mem_command;
            wcount[0]++;
            last_addr[0] = bus_a.mem_addr;
        end
        if (bus_b.mem_write_trigger) begin
            if (bus_b.mem_addr < 16) dmem[1][bus_b.mem_addr[3:0]] = bus_b.mem_command;
            if (bus_b.mem_addr == 16'd4) wrote_addr4[1] = 1'b1;
            wcount[1]++;
            last_addr[1] = bus_b.mem_addr;
        end
        if (cmp_en) begin
            cmp_one(0, bus_a.char_ready, bus_a.mem_write_trigger, bus_a.mem_addr, bus_a.mem_command,
                    bus_a.program_length, bus_a.done, bus_a.error, bus_a.error_code);
            cmp_one(1, bus_b.char_ready, bus_b.mem_write_trigger, bus_b.mem_addr, bus_b.mem_command,
                    bus_b.program_length, bus_b.done, bus_b.error, bus_b.error_code);
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic v,
                       input logic [7:0] d, input logic e);
        reset_trigger       = rst;
        bus_a.start_trigger = st; bus_a.char_valid = v; bus_a.char_data = d; bus_a.end_trigger = e;
        bus_b.start_trigger = st; bus_b.char_valid = v; bus_b.char_data = d; bus_b.end_trigger = e;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, rst, st, v, d, e);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic start();
        wcount[0] = 0; wcount[1] = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b0, 1'b1, s[i], 1'b0);
    endtask

    task automatic finish_src();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [2:0] clean_codes [8];
        clean_codes = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b101, 3'b011, 3'b110};
        bus_a.start_trigger = 1'b0; bus_a.char_valid = 1'b0; bus_a.char_data = 8'h00; bus_a.end_trigger = 1'b0;
        bus_b.start_trigger = 1'b0; bus_b.char_valid = 1'b0; bus_b.char_data = 8'h00; bus_b.end_trigger = 1'b0;

        // Reset state.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cmp_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        check("reset char_ready", bus_a.char_ready, 1'b0);
        check("reset program_length", bus_a.program_length, 16'd0);

        // Clean program; the small loader runs out of space on the fifth command.
        start();
        feed("+[->+<].");
        finish_src();
        idle();
        for (int i = 0; i < 8; i++) check($sformatf("clean mem[%0d]", i), dmem[0][i], clean_codes[i]);
        check("clean writes", wcount[0], 8);
        check("clean length", bus_a.program_length, 16'd8);
        check("clean model length", m_count[0], 8);
        check("clean done", bus_a.done, 1'b1);
        check("clean error_code", bus_a.error_code, 2'b00);
        check("small clean error_code", bus_b.error_code, 2'b11);
        check("small clean length", bus_b.program_length, 16'd4);

        // Filtering of non-command bytes.
        start();
        feed("a+ \n-");
        finish_src();
        idle();
        check("filter writes", wcount[0], 2);
        check("filter mem0", dmem[0][0], 3'b000);
        check("filter mem1", dmem[0][1], 3'b001);
        check("filter length", bus_a.program_length, 16'd2);
        check("filter done", bus_a.done, 1'b1);

        // Unmatched close.
        start();
        feed("+]+");
        idle();
        check("unmatched error", bus_a.error, 1'b1);
        check("unmatched code", bus_a.error_code, 2'b01);
        check("unmatched length", bus_a.program_length, 16'd1);
        check("unmatched ready", bus_a.char_ready, 1'b0);
        check("unmatched writes", wcount[0], 1);

        // Unclosed open.
        start();
        feed("[[]");
        finish_src();
        idle();
        check("unclosed code", bus_a.error_code, 2'b10);
        check("unclosed length", bus_a.program_length, 16'd3);
        check("small unclosed code", bus_b.error_code, 2'b10);

        // Depth and capacity overflow on the small loader.
        start();
        feed("[[[");
        idle();
        check("small depth overflow code", bus_b.error_code, 2'b11);
        check("small depth overflow length", bus_b.program_length, 16'd2);
        check("main deep length", bus_a.program_length, 16'd3);
        start();
        wrote_addr4[1] = 1'b0;
        feed("+++++");
        finish_src();
        idle();
        check("small size overflow code", bus_b.error_code, 2'b11);
        check("small size overflow length", bus_b.program_length, 16'd4);
        check("small no write addr4", wrote_addr4[1], 1'b0);
        check("main five done", bus_a.done, 1'b1);

        // Restart mid-load.
        start();
        feed("++");
        start();
        feed("-");
        idle();
        check("restart addr", last_addr[0], 0);
        check("restart mem0", dmem[0][0], 3'b001);
        check("restart length", bus_a.program_length, 16'd1);

        // End coinciding with a byte: post-byte depth, byte error has priority.
        start();
        feed("[");
        cyc(1'b0, 1'b0, 1'b1, 8'h5D, 1'b1);
        idle();
        check("coincide done", bus_a.done, 1'b1);
        check("coincide length", bus_a.program_length, 16'd2);
        start();
        cyc(1'b0, 1'b0, 1'b1, 8'h5D, 1'b1);
        idle();
        check("coincide byte error code", bus_a.error_code, 2'b01);

        // Reset with a byte, reset after an accepted byte, end outside LOAD.
        start();
        cyc(1'b1, 1'b0, 1'b1, 8'h2B, 1'b0);
        idle();
        check("reset byte writes", wcount[0], 0);
        check("reset byte length", bus_a.program_length, 16'd0);
        start();
        feed("+");
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("post reset write", bus_a.mem_write_trigger, 1'b0);
        check("post reset addr", bus_a.mem_addr, 16'd0);
        check("post reset cmd", bus_a.mem_command, 3'b000);
        check("post reset length", bus_a.program_length, 16'd0);
        check("post reset ready", bus_a.char_ready, 1'b0);
        finish_src();
        idle();
        check("idle end ignored done", bus_a.done, 1'b0);
        check("idle end ignored error", bus_a.error, 1'b0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
